// File: rtl/cursor_controller.sv
`default_nettype none
// ============================================================================
// Module      : cursor_controller
// Description : Turns debounced direction, colour-cycle and width-cycle
//               buttons into a registered cursor position, colour index,
//               stroke width and step size for the canvas/pixel writer.
//               Position moves once per movement tick (every MOVE_DIV
//               cycles) and saturates at the screen edges. Colour and width
//               advance once per button press (rising edge).
// Options     : `define CURSOR_ACCEL_EN enables hold-to-accelerate motion.
//               Without it the step size is fixed at 1 pixel per tick.
// Ports       : clk_in        - system clock
//               rst_in        - asynchronous active-high reset
//               pos_con_in    - direction buttons [3] up [2] down [1] left
//                               [0] right
//               col_con_in    - colour-cycle button
//               sw_con_in     - stroke-width-cycle button
//               cursor_loc_x  - cursor x, 0..H_RES-1
//               cursor_loc_y  - cursor y, 0..V_RES-1
//               cursor_color  - colour index, 0..NUM_COLORS-1
//               stroke_width  - stroke width, 1..MAX_WIDTH
//               speed_out     - current step size in pixels per tick
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_controller #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int NUM_COLORS  = 16,
    parameter int MAX_WIDTH   = 7,
    parameter int MOVE_DIV    = 1_000_000,
    parameter int ACCEL_STEPS = 8,
    parameter int MAX_SPEED   = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [3:0]                       pos_con_in,
    input  logic                             col_con_in,
    input  logic                             sw_con_in,
    output logic [$clog2(H_RES)-1:0]         cursor_loc_x,
    output logic [$clog2(V_RES)-1:0]         cursor_loc_y,
    output logic [$clog2(NUM_COLORS)-1:0]    cursor_color,
    output logic [$clog2(MAX_WIDTH+1)-1:0]   stroke_width,
    output logic [$clog2(MAX_SPEED+1)-1:0]   speed_out
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int c_x_w     = $clog2(H_RES);
    localparam int c_y_w     = $clog2(V_RES);
    localparam int c_color_w = $clog2(NUM_COLORS);
    localparam int c_width_w = $clog2(MAX_WIDTH + 1);
    localparam int c_spd_w   = $clog2(MAX_SPEED + 1);
    // A one-cycle divider still needs a 1-bit counter that simply stays at 0.
    localparam int c_cnt_w   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [c_x_w-1:0]     c_x_rst      = c_x_w'(H_RES / 2);
    localparam logic [c_y_w-1:0]     c_y_rst      = c_y_w'(V_RES / 2);
    localparam logic [c_x_w:0]       c_x_max      = (c_x_w + 1)'(H_RES - 1);
    localparam logic [c_y_w:0]       c_y_max      = (c_y_w + 1)'(V_RES - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_last   = c_cnt_w'(MOVE_DIV - 1);
    localparam logic [c_color_w-1:0] c_color_last = c_color_w'(NUM_COLORS - 1);
    localparam logic [c_width_w-1:0] c_width_one  = c_width_w'(1);
    localparam logic [c_width_w-1:0] c_width_max  = c_width_w'(MAX_WIDTH);
    localparam logic [c_spd_w-1:0]   c_spd_one    = c_spd_w'(1);

    // ------------------------------------------------------------------------
    // Movement tick divider
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_tick_cnt;
    logic               w_tick;

    assign w_tick = (r_tick_cnt == c_cnt_last);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Step size (hold-to-accelerate or fixed)
    // ------------------------------------------------------------------------
    logic [c_spd_w-1:0] w_speed;

`ifdef CURSOR_ACCEL_EN
    localparam int c_hold_w = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(ACCEL_STEPS - 1);
    localparam logic [c_spd_w:0]    c_spd_max   = (c_spd_w + 1)'(MAX_SPEED);

    logic [c_hold_w-1:0] r_hold;
    logic [c_spd_w-1:0]  r_speed;
    logic [c_spd_w:0]    w_speed_dbl;

    // One extra bit so the doubled speed can be compared before saturating.
    assign w_speed_dbl = {r_speed, 1'b0};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hold  <= '0;
            r_speed <= c_spd_one;
        end else if (pos_con_in == 4'b0000) begin
            // Any release, tick or not, drops straight back to slow motion.
            r_hold  <= '0;
            r_speed <= c_spd_one;
        end else if (w_tick) begin
            if (r_hold == c_hold_last) begin
                r_hold <= '0;
                if (w_speed_dbl > c_spd_max) begin
                    r_speed <= c_spd_max[c_spd_w-1:0];
                end else begin
                    r_speed <= w_speed_dbl[c_spd_w-1:0];
                end
            end else begin
                r_hold <= r_hold + c_hold_w'(1);
            end
        end
    end

    assign w_speed = r_speed;
`else
    // Acceleration tuning has no effect here; keep it referenced.
    logic w_unused_accel_cfg;
    assign w_unused_accel_cfg = (ACCEL_STEPS > 0);

    assign w_speed = c_spd_one;
`endif

    // ------------------------------------------------------------------------
    // Direction decode: opposing buttons cancel on each axis
    // ------------------------------------------------------------------------
    logic w_right, w_left, w_down, w_up;

    assign w_right = pos_con_in[0] & ~pos_con_in[1];
    assign w_left  = pos_con_in[1] & ~pos_con_in[0];
    assign w_down  = pos_con_in[2] & ~pos_con_in[3];
    assign w_up    = pos_con_in[3] & ~pos_con_in[2];

    // ------------------------------------------------------------------------
    // Saturating position arithmetic (one guard bit above the coordinate)
    // ------------------------------------------------------------------------
    logic [c_x_w-1:0] r_x;
    logic [c_y_w-1:0] r_y;

    logic [c_x_w:0]   w_x_ext, w_x_step, w_x_sum;
    logic [c_x_w-1:0] w_x_diff, w_x_next;
    logic [c_y_w:0]   w_y_ext, w_y_step, w_y_sum;
    logic [c_y_w-1:0] w_y_diff, w_y_next;

    assign w_x_ext  = {1'b0, r_x};
    assign w_x_step = (c_x_w + 1)'(w_speed);
    assign w_x_sum  = w_x_ext + w_x_step;
    assign w_x_diff = r_x - w_x_step[c_x_w-1:0];

    assign w_y_ext  = {1'b0, r_y};
    assign w_y_step = (c_y_w + 1)'(w_speed);
    assign w_y_sum  = w_y_ext + w_y_step;
    assign w_y_diff = r_y - w_y_step[c_y_w-1:0];

    always_comb begin
        w_x_next = r_x;
        if (w_right) begin
            if (w_x_sum > c_x_max) begin
                w_x_next = c_x_max[c_x_w-1:0];
            end else begin
                w_x_next = w_x_sum[c_x_w-1:0];
            end
        end else if (w_left) begin
            if (w_x_ext < w_x_step) begin
                w_x_next = '0;
            end else begin
                w_x_next = w_x_diff;
            end
        end
    end

    // Screen y grows downwards, so "up" subtracts.
    always_comb begin
        w_y_next = r_y;
        if (w_down) begin
            if (w_y_sum > c_y_max) begin
                w_y_next = c_y_max[c_y_w-1:0];
            end else begin
                w_y_next = w_y_sum[c_y_w-1:0];
            end
        end else if (w_up) begin
            if (w_y_ext < w_y_step) begin
                w_y_next = '0;
            end else begin
                w_y_next = w_y_diff;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_x <= c_x_rst;
            r_y <= c_y_rst;
        end else if (w_tick) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
        end
    end

    // ------------------------------------------------------------------------
    // Colour and width cycling, one step per press
    // ------------------------------------------------------------------------
    logic                 r_col_prev, r_sw_prev;
    logic                 w_col_rise, w_sw_rise;
    logic [c_color_w-1:0] r_color;
    logic [c_width_w-1:0] r_width;

    // History clears on reset, so a button held through release counts once.
    assign w_col_rise = col_con_in & ~r_col_prev;
    assign w_sw_rise  = sw_con_in & ~r_sw_prev;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_col_prev <= 1'b0;
            r_sw_prev  <= 1'b0;
            r_color    <= '0;
            r_width    <= c_width_one;
        end else begin
            r_col_prev <= col_con_in;
            r_sw_prev  <= sw_con_in;
            if (w_col_rise) begin
                if (r_color == c_color_last) begin
                    r_color <= '0;
                end else begin
                    r_color <= r_color + c_color_w'(1);
                end
            end
            // Width wraps MAX_WIDTH -> 1; zero is never produced.
            if (w_sw_rise) begin
                if (r_width == c_width_max) begin
                    r_width <= c_width_one;
                end else begin
                    r_width <= r_width + c_width_one;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cursor_loc_x = r_x;
    assign cursor_loc_y = r_y;
    assign cursor_color = r_color;
    assign stroke_width = r_width;
    assign speed_out    = w_speed;

endmodule

`default_nettype wire

// File: tb/tb_cursor_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cursor_controller
// Description : Directed, self-checking bench for cursor_controller with
//               H_RES=640, V_RES=480, NUM_COLORS=16, MAX_WIDTH=7,
//               MOVE_DIV=2, ACCEL_STEPS=4, MAX_SPEED=4. Inputs change and
//               outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_controller;

    logic       clk;
    logic       rst;
    logic [3:0] pos;
    logic       col;
    logic       sw;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] color;
    logic [2:0] width;
    logic [2:0] speed;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cursor_controller #(
        .H_RES       (640),
        .V_RES       (480),
        .NUM_COLORS  (16),
        .MAX_WIDTH   (7),
        .MOVE_DIV    (2),
        .ACCEL_STEPS (4),
        .MAX_SPEED   (4)
    ) u_dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .pos_con_in   (pos),
        .col_con_in   (col),
        .sw_con_in    (sw),
        .cursor_loc_x (x),
        .cursor_loc_y (y),
        .cursor_color (color),
        .stroke_width (width),
        .speed_out    (speed)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},     int'(x),     320);
        check({tag, "_y"},     int'(y),     240);
        check({tag, "_color"}, int'(color), 0);
        check({tag, "_width"}, int'(width), 1);
        check({tag, "_speed"}, int'(speed), 1);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        pos = 4'b0000;
        col = 1'b0;
        sw  = 1'b0;
        run(2);
        rst = 1'b0;
        check_reset_state("reset");

        // Put some state in place, then reset between edges.
        col = 1'b1;
        run(1);
        check("col_first_step", int'(color), 1);
        col = 1'b0;
        run(1);
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        #1 rst = 1'b0;
        run(1);

        // Colour and width pulses together; width wraps 7 -> 1.
        for (int i = 0; i < 20; i++) begin
            col = 1'b1;
            sw  = 1'b1;
            run(1);
            if (i == 0) begin
                check("cyc1_color", int'(color), 1);
                check("cyc1_width", int'(width), 2);
            end
            if (i == 5) check("cyc6_width", int'(width), 7);
            if (i == 6) begin
                check("cyc7_width_wrap", int'(width), 1);
                check("cyc7_color", int'(color), 7);
            end
            col = 1'b0;
            sw  = 1'b0;
            run(1);
        end
        check("cyc20_color", int'(color), 4);
        check("cyc20_width", int'(width), 7);

        col = 1'b1;
        run(10);
        check("col_hold", int'(color), 5);
        col = 1'b0;
        run(1);
        check("col_hold_release", int'(color), 5);

`ifdef CURSOR_ACCEL_EN
        // Fresh reset so the tick phase starts at counter 0.
        #2 rst = 1'b1;
        #1;
        #1 rst = 1'b0;
        pos = 4'b0001;
        run(8);
        check("accel4_x", int'(x), 324);
        check("accel4_speed", int'(speed), 2);
        run(16);
        check("accel12_x", int'(x), 348);
        check("accel12_speed", int'(speed), 4);
        pos = 4'b0000;
        run(1);
        check("release_speed", int'(speed), 1);
        check("release_x", int'(x), 348);
        run(1);
        pos = 4'b0001;
        run(86);
        check("accel_to500_x", int'(x), 500);
        check("accel_to500_speed", int'(speed), 4);
`else
        pos = 4'b0110;
        run(150);
        check("diag_dl_x", int'(x), 245);
        check("diag_dl_y", int'(y), 315);
        pos = 4'b1001;
        run(150);
        check("diag_ur_x", int'(x), 320);
        check("diag_ur_y", int'(y), 240);
        pos = 4'b0011;
        run(20);
        check("cancel_lr_x", int'(x), 320);
        pos = 4'b1100;
        run(20);
        check("cancel_ud_y", int'(y), 240);
        pos = 4'b0001;
        run(40);
        check("right20_x", int'(x), 340);
        check("fixed_speed", int'(speed), 1);
`endif

        // Reset mid-motion with the colour button already held.
        #2 rst = 1'b1;
        pos = 4'b0000;
        col = 1'b1;
        #1 check_reset_state("mid_rst");
        #1 rst = 1'b0;
        run(3);
        check("held_at_release_color", int'(color), 1);
        col = 1'b0;

        // Clamping at every screen edge.
        pos = 4'b0010;
        run(800);
        check("clamp_left", int'(x), 0);
        run(20);
        check("clamp_left_hold", int'(x), 0);
        pos = 4'b0001;
        run(1400);
        check("clamp_right", int'(x), 639);
        run(20);
        check("clamp_right_hold", int'(x), 639);
        pos = 4'b1000;
        run(800);
        check("clamp_top", int'(y), 0);
        pos = 4'b0100;
        run(1400);
        check("clamp_bottom", int'(y), 479);
        run(20);
        check("clamp_bottom_hold", int'(y), 479);
        pos = 4'b0000;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
